// File: rtl/cic_interp_param.sv
// Parametrised CIC interpolator: N combs, R-fold zero-stuffing upsampler, N integrators, input-ready throttle.
// Optional macro CIC_ROUND_EN: round-half-up by (N-1)*log2(R), saturate to Win bits, one extra output register.
module cic_interp_param #(
    parameter int Win = 16,
    parameter int Wg  = 22,
    parameter int N   = 3,
    parameter int R   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [Win-1:0]    i_data,
    input  logic                     val_in,
    output logic                     in_rdy,
`ifdef CIC_ROUND_EN
    output logic signed [Win-1:0]    o_data,
`else
    output logic signed [Win+Wg-1:0] o_data,
`endif
    output logic                     val_out
);
    localparam int Wf = Win + Wg;
    localparam int Wc = Win + N;
    localparam int GW = $clog2(R);

    logic [GW-1:0] r_gap;
    logic          w_accept;

    assign in_rdy   = (r_gap == '0);
    assign w_accept = val_in && in_rdy;

    // Gap counter: one accept per R clocks keeps the upsampler phase free of collisions
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gap <= '0;
        end else if (w_accept) begin
            r_gap <= GW'(R - 1);
        end else if (r_gap != '0) begin
            r_gap <= r_gap - GW'(1);
        end
    end

    // Stage p0: input register
    logic signed [Win-1:0] r_in_p0;
    logic                  r_vld_p0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_p0  <= '0;
            r_vld_p0 <= 1'b0;
        end else begin
            r_vld_p0 <= w_accept;
            if (w_accept) begin
                r_in_p0 <= i_data;
            end
        end
    end

    // Comb chain: stage k is Win+k bits wide, carried on a common Wc-bit bus
    logic signed [Wc-1:0] w_comb_dat [0:N];
    logic                 w_comb_vld [0:N];

    assign w_comb_dat[0] = Wc'(r_in_p0);
    assign w_comb_vld[0] = r_vld_p0;

    for (genvar k = 1; k <= N; k++) begin : g_comb
        localparam int W = Win + k;
        logic signed [W-2:0] w_x;
        logic signed [W-2:0] r_prev;
        logic signed [W-1:0] r_y;
        logic                r_vld;

        assign w_x = (W-1)'(w_comb_dat[k-1]);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_prev <= '0;
                r_y    <= '0;
                r_vld  <= 1'b0;
            end else begin
                r_vld <= w_comb_vld[k-1];
                if (w_comb_vld[k-1]) begin
                    r_y    <= W'(w_x) - W'(r_prev);
                    r_prev <= w_x;
                end
            end
        end

        assign w_comb_dat[k] = Wc'(r_y);
        assign w_comb_vld[k] = r_vld;
    end

    // Stage p1: upsampler, sample on phase 0 then R-1 zeros
    logic signed [Wf-1:0] r_up_p1;
    logic                 r_vld_p1;
    logic [GW-1:0]        r_phase;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_up_p1  <= '0;
            r_vld_p1 <= 1'b0;
            r_phase  <= '0;
        end else if (w_comb_vld[N]) begin
            r_up_p1  <= Wf'(w_comb_dat[N]);
            r_vld_p1 <= 1'b1;
            r_phase  <= GW'(1);
        end else if (r_phase != '0) begin
            r_up_p1  <= '0;
            r_vld_p1 <= 1'b1;
            r_phase  <= (r_phase == GW'(R - 1)) ? '0 : r_phase + GW'(1);
        end else begin
            r_vld_p1 <= 1'b0;
        end
    end

    // Integrator chain: modular Wf-bit accumulators, advancing only on valid
    logic signed [Wf-1:0] w_int_dat [0:N];
    logic                 w_int_vld [0:N];

    assign w_int_dat[0] = r_up_p1;
    assign w_int_vld[0] = r_vld_p1;

    for (genvar k = 1; k <= N; k++) begin : g_integ
        logic signed [Wf-1:0] r_acc;
        logic                 r_vld;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_acc <= '0;
                r_vld <= 1'b0;
            end else begin
                r_vld <= w_int_vld[k-1];
                if (w_int_vld[k-1]) begin
                    r_acc <= r_acc + w_int_dat[k-1];
                end
            end
        end

        assign w_int_dat[k] = r_acc;
        assign w_int_vld[k] = r_vld;
    end

`ifdef CIC_ROUND_EN
    localparam int                S    = (N - 1) * $clog2(R);
    localparam logic signed [Wf:0] RND  = (S > 0) ? ((Wf+1)'(1) <<< (S > 0 ? S - 1 : 0)) : '0;
    localparam logic signed [Wf:0] MAXV = {{(Wf + 2 - Win){1'b0}}, {(Win - 1){1'b1}}};
    localparam logic signed [Wf:0] MINV = {{(Wf + 2 - Win){1'b1}}, {(Win - 1){1'b0}}};

    function automatic logic signed [Win-1:0] round_sat(input logic signed [Wf-1:0] x);
        logic signed [Wf:0] t;
        t = ((Wf+1)'(x) + RND) >>> S;
        if (t > MAXV) begin
            return Win'(MAXV);
        end else if (t < MINV) begin
            return Win'(MINV);
        end
        return Win'(t);
    endfunction

    // Stage p2: normalised, saturated output register
    logic signed [Win-1:0] r_out_p2;
    logic                  r_vld_p2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_p2 <= '0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_vld_p2 <= w_int_vld[N];
            if (w_int_vld[N]) begin
                r_out_p2 <= round_sat(w_int_dat[N]);
            end
        end
    end

    assign o_data  = r_out_p2;
    assign val_out = r_vld_p2;
`else
    assign o_data  = w_int_dat[N];
    assign val_out = w_int_vld[N];
`endif

endmodule

// File: tb/tb_cic_interp_param.sv
// Self-checking bench for cic_interp_param (N=3, R=4); reference is the CIC impulse response convolved with accepted samples.
module tb_cic_interp_param;
    localparam int Win = 16;
    localparam int Wg  = 22;
    localparam int N   = 3;
    localparam int R   = 4;
    localparam int Wf  = Win + Wg;
    localparam int L   = N * (R - 1) + 1;
`ifdef CIC_ROUND_EN
    localparam int OW  = Win;
    localparam int LAT = 2 * N + 2;
    localparam int S   = (N - 1) * $clog2(R);
`else
    localparam int OW  = Wf;
    localparam int LAT = 2 * N + 1;
`endif

    logic                  clk    = 1'b0;
    logic                  rst    = 1'b1;
    logic signed [Win-1:0] i_data = '0;
    logic                  val_in = 1'b0;
    logic                  in_rdy;
    logic signed [OW-1:0]  o_data;
    logic                  val_out;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    longint h [0:L-1];
    longint xs[$];
    int     acc_cyc[$];
    longint obs[$];
    int     obs_cyc[$];
    bit     rdy_q[$];

    cic_interp_param #(.Win(Win), .Wg(Wg), .N(N), .R(R)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_data (i_data),
        .val_in (val_in),
        .in_rdy (in_rdy),
        .o_data (o_data),
        .val_out(val_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1);
    end

    // A new comb output must never reach the upsampler while it is still stuffing zeros
    always @(negedge clk) begin
        if (rst && dut.w_comb_vld[N]) begin
            checks++;
            if (dut.r_phase !== '0) begin
                errors++;
                $display("FAIL phase_collision: phase=%0d want 0", dut.r_phase);
            end
        end
    end

    // h = coefficients of (1 + z^-1 + ... + z^-(R-1))^N
    task automatic init_h();
        longint t [0:L-1];
        for (int i = 0; i < L; i++) h[i] = 0;
        h[0] = 1;
        for (int n = 1; n <= N; n++) begin
            for (int i = 0; i < L; i++) t[i] = h[i];
            for (int i = 0; i < L; i++) begin
                h[i] = 0;
                for (int j = 0; j < R && j <= i; j++) h[i] += t[i-j];
            end
        end
    endtask

    function automatic longint model_out(int k);
        longint y = 0;
        for (int j = 0; j < xs.size(); j++) begin
            int d = k - j * R;
            if (d >= 0 && d < L) y += xs[j] * h[d];
        end
        y = (y <<< (64 - Wf)) >>> (64 - Wf);
`ifdef CIC_ROUND_EN
        if (S > 0) y = (y + (longint'(1) <<< (S - 1))) >>> S;
        if (y > (longint'(1) <<< (Win - 1)) - 1) y = (longint'(1) <<< (Win - 1)) - 1;
        if (y < -(longint'(1) <<< (Win - 1)))    y = -(longint'(1) <<< (Win - 1));
`endif
        return y;
    endfunction

    function automatic longint rnd_sample();
        logic signed [Win-1:0] v;
        v = Win'($urandom);
        return longint'(v);
    endfunction

    // One clock: drive at posedge+1, observe at the next posedge+1
    task automatic step(input bit v, input longint d);
        logic [63:0] dv;
        dv = d;
        val_in = v;
        i_data = dv[Win-1:0];
        #1;
        rdy_q.push_back(in_rdy);
        if (v && in_rdy) begin
            xs.push_back(d);
            acc_cyc.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (val_out) begin
            obs.push_back(longint'(o_data));
            obs_cyc.push_back(cyc);
        end
    endtask

    task automatic send(input longint d);
        int n0 = xs.size();
        for (int t = 0; t < 4 * R && xs.size() == n0; t++) step(1'b1, d);
        if (xs.size() == n0) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: sample %0d not accepted in %0d cycles", d, 4 * R);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0);
    endtask

    task automatic clear_model();
        xs.delete();
        acc_cyc.delete();
        obs.delete();
        obs_cyc.delete();
        rdy_q.delete();
    endtask

    task automatic do_reset();
        val_in = 1'b0;
        rst    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_model();
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (val_out !== 1'b0) begin errors++; $display("FAIL reset_val_out: got %b want 0", val_out); end
        checks++;
        if (o_data !== '0) begin errors++; $display("FAIL reset_o_data: got %0d want 0", o_data); end
        checks++;
        if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %b want 1", in_rdy); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_model();
    endtask

    task automatic test_impulse(input string tag);
        longint imp_exp [0:11];
`ifdef CIC_ROUND_EN
        imp_exp = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0};
`else
        imp_exp = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1, 0, 0};
`endif
        send(1);
        send(0);
        send(0);
        idle(2 * N + 2 * R + 4);
        checks++;
        if (obs.size() != 3 * R) begin
            errors++;
            $display("FAIL %s_count: got %0d outputs want %0d", tag, obs.size(), 3 * R);
        end
        for (int k = 0; k < obs.size() && k < 12; k++) begin
            checks++;
            if (obs[k] !== imp_exp[k]) begin
                errors++;
                $display("FAIL %s_value[%0d]: got %0d want %0d", tag, k, obs[k], imp_exp[k]);
            end
        end
        checks++;
        if (obs.size() == 0 || acc_cyc.size() == 0 || obs_cyc[0] - acc_cyc[0] != LAT) begin
            errors++;
            $display("FAIL %s_latency: got %0d want %0d", tag,
                     (obs.size() > 0 && acc_cyc.size() > 0) ? obs_cyc[0] - acc_cyc[0] : -1, LAT);
        end
        checks++;
        if (obs.size() == 0 || obs_cyc[obs.size()-1] - obs_cyc[0] != obs.size() - 1) begin
            errors++;
            $display("FAIL %s_contiguous: val_out not continuous over %0d outputs", tag, obs.size());
        end
    endtask

    task automatic test_dc();
        longint dc_in  [0:2] = '{100, -32768, 32767};
`ifdef CIC_ROUND_EN
        longint dc_exp [0:2] = '{100, -32768, 32767};
`else
        longint dc_exp [0:2] = '{1600, -524288, 524272};
`endif
        for (int v = 0; v < 3; v++) begin
            do_reset();
            for (int i = 0; i < 20; i++) send(dc_in[v]);
            idle(2 * N + 2 * R + 4);
            checks++;
            if (obs.size() != 20 * R) begin
                errors++;
                $display("FAIL dc_count(%0d): got %0d want %0d", dc_in[v], obs.size(), 20 * R);
            end
            for (int k = L - 1; k < obs.size(); k++) begin
                checks++;
                if (obs[k] !== dc_exp[v]) begin
                    errors++;
                    $display("FAIL dc_value(%0d)[%0d]: got %0d want %0d", dc_in[v], k, obs[k], dc_exp[v]);
                end
            end
            checks++;
            if (obs.size() == 0 || obs_cyc[obs.size()-1] - obs_cyc[0] != obs.size() - 1) begin
                errors++;
                $display("FAIL dc_contiguous(%0d): val_out gaps over %0d outputs", dc_in[v], obs.size());
            end
        end
    endtask

    task automatic test_handshake();
        int nrdy = 0;
        do_reset();
        for (int i = 0; i < 12 * R; i++) step(1'b1, rnd_sample());
        foreach (rdy_q[i]) if (rdy_q[i]) nrdy++;
        idle(2 * N + 2 * R + 4);
        checks++;
        if (xs.size() != 12) begin
            errors++;
            $display("FAIL hs_accepts: got %0d want %0d", xs.size(), 12);
        end
        checks++;
        if (nrdy != xs.size()) begin
            errors++;
            $display("FAIL hs_rdy_pulses: got %0d ready cycles want %0d", nrdy, xs.size());
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != R) begin
                errors++;
                $display("FAIL hs_spacing[%0d]: got %0d want %0d", i, acc_cyc[i] - acc_cyc[i-1], R);
            end
        end
        checks++;
        if (obs.size() != R * xs.size()) begin
            errors++;
            $display("FAIL hs_out_count: got %0d want %0d", obs.size(), R * xs.size());
        end
        for (int k = 0; k < obs.size(); k++) begin
            checks++;
            if (obs[k] !== model_out(k)) begin
                errors++;
                $display("FAIL hs_value[%0d]: got %0d want %0d", k, obs[k], model_out(k));
            end
        end
    endtask

    task automatic test_gaps();
        longint held;
        do_reset();
        send(rnd_sample());
        idle(13);
        held = (obs.size() > 0) ? obs[obs.size()-1] : 0;
        checks++;
        if (obs.size() != R || longint'(o_data) !== held) begin
            errors++;
            $display("FAIL gap_hold: got %0d outputs, o_data %0d, want %0d outputs holding %0d",
                     obs.size(), o_data, R, held);
        end
        send(rnd_sample());
        for (int i = 0; i < 30; i++) begin
            idle($urandom_range(0, 6));
            send(rnd_sample());
        end
        idle(2 * N + 2 * R + 4);
        checks++;
        if (obs.size() != R * xs.size()) begin
            errors++;
            $display("FAIL gap_out_count: got %0d want %0d", obs.size(), R * xs.size());
        end
        for (int i = 0; i < acc_cyc.size() && (i + 1) * R <= obs.size(); i++) begin
            checks++;
            if (obs_cyc[i*R] - acc_cyc[i] != LAT || obs_cyc[i*R+R-1] - obs_cyc[i*R] != R - 1) begin
                errors++;
                $display("FAIL gap_group[%0d]: latency got %0d want %0d, span got %0d want %0d", i,
                         obs_cyc[i*R] - acc_cyc[i], LAT, obs_cyc[i*R+R-1] - obs_cyc[i*R], R - 1);
            end
        end
        for (int k = 0; k < obs.size(); k++) begin
            checks++;
            if (obs[k] !== model_out(k)) begin
                errors++;
                $display("FAIL gap_value[%0d]: got %0d want %0d", k, obs[k], model_out(k));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(1);
        send(0);
        for (int t = 0; t < 40 && obs.size() < 2; t++) step(1'b0, 0);
        checks++;
        if (obs.size() != 2) begin
            errors++;
            $display("FAIL rmid_wait: got %0d outputs want 2", obs.size());
        end
        rst = 1'b0;
        #1;
        checks++;
        if (val_out !== 1'b0) begin errors++; $display("FAIL rmid_val_out: got %b want 0", val_out); end
        checks++;
        if (o_data !== '0) begin errors++; $display("FAIL rmid_o_data: got %0d want 0", o_data); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_model();
        checks++;
        if (in_rdy !== 1'b1) begin errors++; $display("FAIL rmid_in_rdy: got %b want 1", in_rdy); end
        idle(20);
        checks++;
        if (obs.size() != 0) begin
            errors++;
            $display("FAIL rmid_residue: got %0d outputs after reset want 0", obs.size());
        end
        clear_model();
        test_impulse("rmid_imp");
    endtask

    initial begin
        init_h();
        test_reset();
        test_impulse("imp");
        test_dc();
        test_handshake();
        test_gaps();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cic_interp_param.md
Name: cic_interp_param

Overview:
- Parametrised full-precision CIC interpolator; successor to the fixed order-3 CIC chain.
- Order N and rate R are parameters; structure is N combs, then a zero-stuffing upsampler, then N integrators, all built with generate loops.
- Adds an input-ready handshake so upstream throttles to one sample per R clocks.
- Sits between the baseband sample source and the DAC-rate datapath.

Parameters:
- Win, 16, input sample width (signed two's complement).
- Wg, 22, guard bits; full-precision width Wf = Win+Wg; must satisfy Wg >= N*clog2(R).
- N, 3, filter order (number of comb and integrator stages), legal range 1..6.
- R, 4, interpolation factor, legal range 2..1024.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- i_data  in  Win  signed input sample.
- val_in  in  1  input valid.
- in_rdy  out  1  input ready; a sample is accepted when val_in & in_rdy at a clk rising edge.
- o_data  out  Wf (Win with CIC_ROUND_EN)  signed output sample.
- val_out  out  1  output valid, one pulse per output sample.

Behaviour:
- Reset (rst=0, asynchronous): all comb delay, comb output, upsampler, integrator and output registers clear to 0.
  - All valid flags clear to 0; gap counter and phase counter clear to 0.
  - val_out=0, o_data=0, in_rdy=1.
  - Reset mid-burst aborts the burst. No output is produced for partially processed samples after rst returns high.
- Gap counter (width clog2(R)): on accept, load R-1; otherwise decrement while nonzero. in_rdy = (gap_cnt==0), combinational.
  - val_in while in_rdy=0 is ignored and the sample is not stored.
- Comb stage k (k=1..N): width Win+k.
  - On valid: y = x - x_prev (sign-extended), x_prev <= x; registered, 1 cycle per stage.
  - Stage holds its data and clears its valid when its input is not valid.
- Upsampler, on a valid from comb N:
  - Loads that sample sign-extended to Wf, sets phase=1, asserts valid.
  - On each of the next R-1 cycles, outputs 0 with valid=1, phase increments; phase wraps to 0 after R-1.
  - The gap counter guarantees no new comb output arrives while phase != 0. A collision is a design error and a bench assertion.
- Integrator stage k (k=1..N): width Wf.
  - acc <= acc + x on valid only, with modular two's-complement wrap (no saturation). Registered, 1 cycle per stage.
- Latency: sample accepted at edge t gives its first output at edge t+2N+1. R consecutive val_out=1 cycles follow per accepted input.
- With back-to-back inputs (one every R cycles), val_out is continuously 1. Gaps in the input produce gaps in val_out; state is retained across gaps.
- DC gain = R^(N-1). Output is exact while |result| < 2^(Wf-1).

Optional Feature:
- Macro CIC_ROUND_EN.
- Defined (requires R a power of two):
  - Output is normalised by s = (N-1)*log2(R): o_data = (acc + 2^(s-1)) >>> s, with round-half-up (no offset when s=0).
  - Result saturates to the Win signed range; o_data width is Win.
  - One extra output register; latency becomes 2N+2.
- Undefined: o_data is the full Wf-bit integrator N output; latency 2N+1.

Test Plan:
- Impulse (N=3, R=4, macro off): feed 1,0,0 at one input per 4 cycles -> o_data sequence 1,3,6,10,12,12,10,6,3,1,0,0 with val_out=1 for 12 consecutive cycles; first output 7 cycles after accept.
- DC: constant input 100, back-to-back for 20 inputs -> steady o_data=1600 every cycle. Constant -32768 -> steady -524288, no overflow.
- Handshake: hold val_in=1 continuously -> in_rdy pulses high 1 cycle in every 4, exactly one accept per 4 cycles, no phase collision assertion fires.
- Reset mid-operation: rst=0 for 1 cycle during the 2nd output of a burst -> val_out=0 and o_data=0 immediately (async). After release, in_rdy=1 and the impulse test repeats bit-exactly.
- CIC_ROUND_EN (N=3, R=4, s=4): DC input 100 -> o_data=100. Input 32767 -> 32767, no wrap. Impulse output 10 -> (10+8)>>4 = 1; output 6 -> 0. Latency 8.
- Input gaps: accept, idle 13 cycles, accept -> exactly 4 val_out per accept, accumulators unchanged during idle, outputs match the gapless sequence.
